// File: rtl/flaf_logmac_seq_if.sv
// Handshake and data bundle between the log-domain expansion stage, the serial MAC and the error/update stage.
// The producer/consumer side uses master; the MAC uses slave.
interface flaf_logmac_seq_if #(
  parameter int Q_ORD     = 7,
  parameter int WIDTH     = 16,
  parameter int LOG_WIDTH = 17
);
  logic                        in_valid;
  logic                        in_ready;
  logic [Q_ORD*LOG_WIDTH-1:0]  nonl_x_in_packed;
  logic [Q_ORD-1:0]            nonl_x_in_sign_packed;
  logic [Q_ORD-1:0]            nonl_x_in_valid_packed;
  logic [Q_ORD*WIDTH-1:0]      w_in_packed;
  logic signed [WIDTH-1:0]     y_out;
  logic                        y_valid;
  logic                        y_ready;
  logic                        y_sat;

  modport master (
    output in_valid, nonl_x_in_packed, nonl_x_in_sign_packed, nonl_x_in_valid_packed,
           w_in_packed, y_ready,
    input  in_ready, y_out, y_valid, y_sat
  );

  modport slave (
    input  in_valid, nonl_x_in_packed, nonl_x_in_sign_packed, nonl_x_in_valid_packed,
           w_in_packed, y_ready,
    output in_ready, y_out, y_valid, y_sat
  );
endinterface

// File: rtl/flaf_logmac_seq.sv
// Serial log-domain MAC: y = sum w_i * antilog(L_i), one term per cycle; y_valid Q_ORD+1 cycles after accept.
// Input stalls (in_ready=0) from acceptance until y_out is taken; y_out/y_valid/y_sat hold while y_ready=0.
module flaf_logmac_seq #(
  parameter int Q_ORD     = 7,
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LOG_WIDTH = 17,
  parameter int ACC_WIDTH = 24
) (
  input logic               clk,
  input logic               reset,
  flaf_logmac_seq_if.slave  bus
);
  localparam int CW = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
  localparam int EW = LOG_WIDTH - 12;
  localparam int TW = WIDTH + 13 + (1 << (EW - 1));

  localparam logic [TW-1:0]               T_MAX   = TW'({(ACC_WIDTH-1){1'b1}});
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX   = ACC_WIDTH'({(WIDTH-1){1'b1}});
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN   = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                         st;
  logic [CW-1:0]                  cnt;
  logic [Q_ORD*LOG_WIDTH-1:0]     x_q;
  logic [Q_ORD-1:0]               s_q;
  logic [Q_ORD-1:0]               v_q;
  logic [Q_ORD*WIDTH-1:0]         w_q;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic                           sat;
  logic                           in_rdy_q;
  logic signed [WIDTH-1:0]        y_q;
  logic                           y_vld_q;
  logic                           y_sat_q;

  logic [LOG_WIDTH-1:0]           l_cur;
  logic [WIDTH-1:0]               w_cur;
  logic [WIDTH-1:0]               wmag;
  logic signed [EW-1:0]           e;
  logic [12:0]                    m;
  logic [TW-1:0]                  p;
  logic [TW-1:0]                  t;
  logic [ACC_WIDTH-2:0]           tc;
  logic [ACC_WIDTH:0]             sum;
  logic                           live;
  logic                           neg;
  logic                           t_sat;
  logic                           a_ovf;
  logic signed [ACC_WIDTH-1:0]    acc_nxt;
  logic                           sat_nxt;
  logic                           y_hi;
  logic                           y_lo;
  logic signed [WIDTH-1:0]        y_nxt;
  int                             sh;

  always_comb begin
    l_cur = x_q[int'(cnt)*LOG_WIDTH +: LOG_WIDTH];
    w_cur = w_q[int'(cnt)*WIDTH +: WIDTH];
    live  = v_q[cnt] && (w_cur != '0);
    neg   = s_q[cnt] ^ w_cur[WIDTH-1];
    // Two's-complement negate read as unsigned gives |-32768| = 32768.
    wmag  = w_cur[WIDTH-1] ? (-w_cur) : w_cur;
    e     = l_cur[LOG_WIDTH-1:12];
    m     = {1'b1, l_cur[11:0]};
    p     = TW'(wmag) * TW'(m);
    sh    = QP - int'(e);
    t     = p;
    if (sh > 0)
      t = (p + (TW'(1) << (sh - 1))) >> sh;
    else if (sh < 0)
      t = p << (-sh);
    t_sat = (t > T_MAX);
    tc    = t_sat ? {(ACC_WIDTH-1){1'b1}} : t[ACC_WIDTH-2:0];
    sum   = neg ? ({acc[ACC_WIDTH-1], acc} - {2'b00, tc})
                : ({acc[ACC_WIDTH-1], acc} + {2'b00, tc});
    a_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    acc_nxt = acc;
    if (live)
      acc_nxt = a_ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
    sat_nxt = sat | (live & (t_sat | a_ovf));
    y_hi    = (acc_nxt > Y_MAX);
    y_lo    = (acc_nxt < Y_MIN);
    y_nxt   = acc_nxt[WIDTH-1:0];
    if (y_hi)
      y_nxt = {1'b0, {(WIDTH-1){1'b1}}};
    else if (y_lo)
      y_nxt = {1'b1, {(WIDTH-1){1'b0}}};
  end

  // The last term loads y_out directly so y_valid appears the cycle after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      cnt      <= '0;
      x_q      <= '0;
      s_q      <= '0;
      v_q      <= '0;
      w_q      <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      in_rdy_q <= 1'b0;
      y_q      <= '0;
      y_vld_q  <= 1'b0;
      y_sat_q  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          in_rdy_q <= 1'b1;
          if (bus.in_valid && in_rdy_q) begin
            x_q      <= bus.nonl_x_in_packed;
            s_q      <= bus.nonl_x_in_sign_packed;
            v_q      <= bus.nonl_x_in_valid_packed;
            w_q      <= bus.w_in_packed;
            acc      <= '0;
            sat      <= 1'b0;
            cnt      <= '0;
            in_rdy_q <= 1'b0;
            st       <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          sat <= sat_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(Q_ORD - 1)) begin
            y_q     <= y_nxt;
            y_sat_q <= sat_nxt | y_hi | y_lo;
            y_vld_q <= 1'b1;
            st      <= OUT;
          end
        end
        OUT: begin
          if (bus.y_ready) begin
            y_vld_q  <= 1'b0;
            in_rdy_q <= 1'b1;
            st       <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_rdy_q;
  assign bus.y_out    = y_q;
  assign bus.y_valid  = y_vld_q;
  assign bus.y_sat    = y_sat_q;
endmodule

// File: tb/tb_flaf_logmac_seq.sv
// Directed bench for flaf_logmac_seq: hand-computed vectors, latency, backpressure and mid-run reset.
module tb_flaf_logmac_seq;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   acc_cyc;

  logic [16:0] tl [7];
  logic [15:0] tw [7];
  logic [6:0]  ts;
  logic [6:0]  tv;

  flaf_logmac_seq_if #(.Q_ORD(7), .WIDTH(16), .LOG_WIDTH(17)) bus ();

  flaf_logmac_seq #(.Q_ORD(7), .WIDTH(16), .QP(12), .LOG_WIDTH(17), .ACC_WIDTH(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1);
  end

  task clear_vec();
    for (int i = 0; i < 7; i++) begin
      tl[i] = '0;
      tw[i] = '0;
    end
    ts = '0;
    tv = '0;
  endtask

  task pack_vec();
    for (int i = 0; i < 7; i++) begin
      bus.nonl_x_in_packed[17*i +: 17] = tl[i];
      bus.w_in_packed[16*i +: 16]      = tw[i];
    end
    bus.nonl_x_in_sign_packed  = ts;
    bus.nonl_x_in_valid_packed = tv;
  endtask

  // Presents the vector, waits for acceptance, then scrambles the bus to show it is not resampled.
  task drive_vec();
    int k;
    pack_vec();
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.in_valid               = 1'b0;
    bus.nonl_x_in_packed       = '1;
    bus.nonl_x_in_sign_packed  = '1;
    bus.nonl_x_in_valid_packed = '1;
    bus.w_in_packed            = '1;
  endtask

  task collect(output logic [15:0] y, output logic s, output int lat);
    bus.y_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.y_valid && lat < 40);
    if (!bus.y_valid) begin
      total++;
      bad++;
      $display("FAIL y_valid_timeout: y_valid=%0b required 1", bus.y_valid);
    end
    y = bus.y_out;
    s = bus.y_sat;
    @(posedge clk);
    #1;
  endtask

  task test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.y_ready  = 1'b1;
    clear_vec();
    pack_vec();
    repeat (3) @(negedge clk);
    total += 4;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b required 0", bus.in_ready); end
    if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL rst_y_valid: got %0b required 0", bus.y_valid); end
    if (bus.y_out !== 16'h0000) begin bad++; $display("FAIL rst_y_out: got %h required 0000", bus.y_out); end
    if (bus.y_sat !== 1'b0) begin bad++; $display("FAIL rst_y_sat: got %0b required 0", bus.y_sat); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %0b required 1", bus.in_ready); end
  endtask

  task test_unity();
    logic [15:0] y; logic s; int lat;
    clear_vec();
    for (int i = 0; i < 7; i++) tw[i] = 16'd4096;
    tv = 7'h7F;
    drive_vec();
    collect(y, s, lat);
    total += 3;
    if (y !== 16'd28672) begin bad++; $display("FAIL unity_y: got %0d required 28672", $signed(y)); end
    if (s !== 1'b0) begin bad++; $display("FAIL unity_sat: got %0b required 0", s); end
    if (lat !== 8) begin bad++; $display("FAIL unity_latency: got %0d required 8", lat); end
  endtask

  task test_mixed();
    logic [15:0] y; logic s; int lat;
    clear_vec();
    tl[0] = 17'h1F000; tw[0] = 16'd4096;
    tl[1] = 17'h00000; tw[1] = 16'd1024; ts[1] = 1'b1;
    tw[4] = 16'd777;
    tv = 7'b0000011;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'd1024) begin bad++; $display("FAIL mixed_y: got %0d required 1024", $signed(y)); end
    if (s !== 1'b0) begin bad++; $display("FAIL mixed_sat: got %0b required 0", s); end
  endtask

  task test_frac_and_zero();
    logic [15:0] y; logic s; int lat;
    clear_vec();
    tl[0] = 17'd2048; tw[0] = 16'hF000;
    tv = 7'b0000001;
    drive_vec();
    collect(y, s, lat);
    total++;
    if (y !== 16'hE800) begin bad++; $display("FAIL frac_y: got %0d required -6144", $signed(y)); end
    clear_vec();
    tw[0] = 16'd4096; tw[1] = 16'd4096; tw[2] = 16'd0;
    tv = 7'b0000100;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'h0000) begin bad++; $display("FAIL zero_w_y: got %0d required 0", $signed(y)); end
    if (s !== 1'b0) begin bad++; $display("FAIL zero_w_sat: got %0b required 0", s); end
    clear_vec();
    for (int i = 0; i < 7; i++) tw[i] = 16'h7FFF;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'h0000) begin bad++; $display("FAIL all_invalid_y: got %0d required 0", $signed(y)); end
    if (s !== 1'b0) begin bad++; $display("FAIL all_invalid_sat: got %0b required 0", s); end
  endtask

  task test_sat();
    logic [15:0] y; logic s; int lat;
    clear_vec();
    for (int i = 0; i < 7; i++) begin tl[i] = 17'h03000; tw[i] = 16'h7FFF; end
    tv = 7'h7F;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_y: got %0d required 32767", $signed(y)); end
    if (s !== 1'b1) begin bad++; $display("FAIL sat_pos_flag: got %0b required 1", s); end
    ts = 7'h7F;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'h8000) begin bad++; $display("FAIL sat_neg_y: got %0d required -32768", $signed(y)); end
    if (s !== 1'b1) begin bad++; $display("FAIL sat_neg_flag: got %0b required 1", s); end
    clear_vec();
    tl[0] = 17'h0FFFF; tw[0] = 16'h8000;
    tv = 7'b0000001;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'h8000) begin bad++; $display("FAIL term_clamp_y: got %0d required -32768", $signed(y)); end
    if (s !== 1'b1) begin bad++; $display("FAIL term_clamp_flag: got %0b required 1", s); end
  endtask

  task test_emin();
    logic [15:0] y; logic s; int lat;
    clear_vec();
    tl[0] = 17'h10000; tw[0] = 16'h8000;
    tl[1] = 17'h10000; tw[1] = 16'h7FFF;
    tv = 7'b0000011;
    drive_vec();
    collect(y, s, lat);
    total += 2;
    if (y !== 16'hFFFF) begin bad++; $display("FAIL emin_y: got %0d required -1", $signed(y)); end
    if (s !== 1'b0) begin bad++; $display("FAIL emin_sat: got %0b required 0", s); end
  endtask

  task test_back_to_back();
    logic [15:0] y; logic s; int lat; int first;
    clear_vec();
    for (int i = 0; i < 7; i++) tw[i] = 16'd4096;
    tv = 7'h7F;
    drive_vec();
    first = acc_cyc;
    collect(y, s, lat);
    drive_vec();
    total++;
    if (acc_cyc - first !== 9) begin bad++; $display("FAIL b2b_interval: got %0d required 9", acc_cyc - first); end
    collect(y, s, lat);
    total++;
    if (y !== 16'd28672) begin bad++; $display("FAIL b2b_y: got %0d required 28672", $signed(y)); end
  endtask

  task test_backpressure();
    logic [15:0] y; logic s; int lat; int k;
    clear_vec();
    for (int i = 0; i < 7; i++) tw[i] = 16'd4096;
    tv = 7'h7F;
    bus.y_ready = 1'b0;
    drive_vec();
    k = 0;
    while (!bus.y_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    clear_vec();
    tl[0] = 17'h1F000; tw[0] = 16'd4096;
    tw[1] = 16'd1024; ts[1] = 1'b1;
    tv = 7'b0000011;
    pack_vec();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total += 3;
      if (bus.y_valid !== 1'b1) begin bad++; $display("FAIL bp_y_valid c%0d: got %0b required 1", c, bus.y_valid); end
      if (bus.y_out !== 16'd28672) begin bad++; $display("FAIL bp_y_out c%0d: got %0d required 28672", c, $signed(bus.y_out)); end
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d: got %0b required 0", c, bus.in_ready); end
    end
    bus.y_ready = 1'b1;
    @(posedge clk);
    #1;
    total += 2;
    if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL bp_release_y_valid: got %0b required 0", bus.y_valid); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %0b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept_next: in_ready got %0b required 0", bus.in_ready); end
    collect(y, s, lat);
    total += 2;
    if (y !== 16'd1024) begin bad++; $display("FAIL bp_next_y: got %0d required 1024", $signed(y)); end
    if (lat !== 8) begin bad++; $display("FAIL bp_next_latency: got %0d required 8", lat); end
  endtask

  task test_reset_mid();
    logic [15:0] y; logic s; int lat; int seen;
    clear_vec();
    for (int i = 0; i < 7; i++) begin tl[i] = 17'h03000; tw[i] = 16'h7FFF; end
    tv = 7'h7F;
    drive_vec();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total += 4;
    if (bus.y_out !== 16'h0000) begin bad++; $display("FAIL mid_rst_y_out: got %h required 0000", bus.y_out); end
    if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_y_valid: got %0b required 0", bus.y_valid); end
    if (bus.y_sat !== 1'b0) begin bad++; $display("FAIL mid_rst_y_sat: got %0b required 0", bus.y_sat); end
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready: got %0b required 0", bus.in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.y_valid) seen++;
    end
    total += 2;
    if (seen !== 0) begin bad++; $display("FAIL mid_rst_residue: y_valid cycles got %0d required 0", seen); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_release_in_ready: got %0b required 1", bus.in_ready); end
    clear_vec();
    tl[0] = 17'd2048; tw[0] = 16'hF000;
    tv = 7'b0000001;
    drive_vec();
    collect(y, s, lat);
    total += 3;
    if (y !== 16'hE800) begin bad++; $display("FAIL mid_rst_fresh_y: got %0d required -6144", $signed(y)); end
    if (s !== 1'b0) begin bad++; $display("FAIL mid_rst_fresh_sat: got %0b required 0", s); end
    if (lat !== 8) begin bad++; $display("FAIL mid_rst_fresh_latency: got %0d required 8", lat); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_unity();
    test_mixed();
    test_frac_and_zero();
    test_sat();
    test_emin();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flaf_logmac_seq.md
Name: flaf_logmac_seq

Overview:
- Downstream consumer of the log-domain functional-link expansion stage.
- Takes one packed vector of Q_ORD log-magnitude features (signed Q5.12 log2), their sign bits and their valid bits, plus a matching packed weight vector.
- Forms y = sum_i w_i * phi_i serially, one term per cycle: Mitchell antilog, magnitude multiply, shift, signed saturating accumulate.
- Presents the filter output with a valid/ready handshake to the error/update stage.

Parameters:
- Q_ORD, 7, number of expansion terms per vector.
- WIDTH, 16, weight and output width, signed, QP fractional bits.
- QP, 12, fractional bits of weights and output.
- LOG_WIDTH, 17, width of each log feature; low 12 bits are fraction, upper bits are signed integer.
- ACC_WIDTH, 24, signed accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- nonl_x_in_packed  in  Q_ORD*LOG_WIDTH  log2|phi_i|, term i at [LOG_WIDTH*i +: LOG_WIDTH].
- nonl_x_in_sign_packed  in  Q_ORD  sign of phi_i (1 = negative).
- nonl_x_in_valid_packed  in  Q_ORD  0 means phi_i == 0; the term is skipped.
- w_in_packed  in  Q_ORD*WIDTH  signed weights, QP fractional bits.
- y_out  out  WIDTH  signed filter output, QP fractional bits.
- y_valid  out  1  y_out valid.
- y_ready  in  1  downstream accepts y_out.
- y_sat  out  1  saturation occurred in this vector.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, in_ready=0 during reset, y_out=0, y_valid=0, y_sat=0, accumulator=0, term counter=0. First cycle after release: in_ready=1.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register all input buses, clear accumulator and sat flag, cnt=0, go to MAC.
  - Inputs are sampled only at acceptance; later changes are ignored.
- MAC:
  - in_ready=0. Each cycle processes term cnt.
  - If valid bit is 0 or w==0: the term contributes 0.
  - Otherwise:
    - L = log feature; e = L[LOG_WIDTH-1:12] (signed), f = L[11:0].
    - m = 4096 + f (13-bit unsigned Mitchell mantissa, Q1.12).
    - p = |w| * m (|-32768| = 32768).
    - sh = QP - e.
    - If sh > 0: t = (p + 2^(sh-1)) >> sh (round half-up on magnitude).
    - If sh == 0: t = p.
    - If sh < 0: t = p << -sh.
    - Clamp t to 2^(ACC_WIDTH-1)-1 and set sat if clamped.
    - Term sign = sign_bit XOR w[WIDTH-1]. acc = acc ± t, saturating at ACC_WIDTH signed limits; set sat on clamp.
  - cnt increments. After cnt == Q_ORD-1 is processed, go to OUT.
- OUT:
  - y_out = acc saturated to WIDTH signed (sets y_sat if clamped). y_sat reflects any clamp in this vector. y_valid=1.
  - y_out, y_valid and y_sat hold stable while y_ready=0.
  - On y_ready: y_valid drops next cycle and the FSM returns to IDLE.
- Latency and throughput:
  - Accept at cycle 0 -> y_valid at cycle Q_ORD+1 (Q_ORD=7: cycle 8).
  - Back-to-back throughput is one vector per Q_ORD+2 cycles with y_ready held high.
- Boundary conditions:
  - All valid bits 0 -> y_out=0, y_sat=0.
  - e at its minimum (-16): sh=28, the term rounds to 0 or 1.
  - Simultaneous y_ready and in_valid in OUT: in_valid is not accepted that cycle; it is accepted in IDLE the next cycle.
  - reset asserted mid-MAC or in OUT: immediate abort to reset values, no partial output.

Test Plan:
- Q_ORD=7, all logs 0 (1.0), signs 0, valid all 1, weights 4096 -> y_out=28672, y_sat=0, y_valid exactly 8 cycles after acceptance.
- Term 0: log=-4096 (17'h1F000, 0.5), w=4096; term 1: log=0, sign=1, w=1024; others invalid -> y_out=2048-1024=1024.
- Log fraction test, term 0 only: L=2048 (Mitchell 1.5), w=-4096 -> y_out=-6144. Single term with all valid bits 0 except an entry that has w=0 -> y_out=0.
- Saturation: all terms log=3<<12 (8.0), w=32767 -> y_out=32767, y_sat=1. Same with all signs=1 -> y_out=-32768, y_sat=1.
- Backpressure: y_ready=0 for 5 cycles in OUT -> y_out and y_valid stable, in_ready=0, new in_valid ignored. Raise y_ready -> IDLE, next vector accepted one cycle later.
- Assert reset at MAC cycle 3 -> all outputs 0 immediately. After release, in_ready=1 and a fresh vector produces the correct result with no residue.
